// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Covers PC source select, mult/div FSM states and timing-field width.
package pipe_hazard_ctrl_pkg;
  localparam int TW = 2;
  localparam logic [1:0] PC_NORM = 2'd0;
  localparam logic [1:0] PC_EXC  = 2'd1;
  localparam logic [1:0] PC_EPC  = 2'd2;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_st_e;
endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// Mult/div busy tracker: loads a latency on start, counts down to idle.
// A start seen while already busy is ignored.
module md_busy_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  output logic busy
);
  md_st_e           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    case (st)
      ST_IDLE: begin
        if (start) begin
          st_n  = ST_BUSY;
          cnt_n = div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      ST_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) st_n = ST_IDLE;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  assign busy = (st == ST_BUSY);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline.
// Define HAZ_STATS_EN to add the saturating stall_cnt output.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    rsD,
  input  logic [4:0]    rtD,
  input  logic [TW-1:0] tuse_rsD,
  input  logic [TW-1:0] tuse_rtD,
  input  logic [4:0]    wregE,
  input  logic [TW-1:0] tnewE,
  input  logic [4:0]    wregM,
  input  logic [TW-1:0] tnewM,
  input  logic          md_startE,
  input  logic          md_divE,
  input  logic          md_useD,
  input  logic          exc_reqM,
  input  logic          eretM,
  output logic          stallF,
  output logic          stallD,
  output logic          Eclr,
  output logic          DEMWclr,
  output logic [1:0]    pc_sel,
`ifdef HAZ_STATS_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          md_busy
);
  logic rs_e, rs_m, rt_e, rt_m;
  logic stall_data, stall_md, stall, flush, busy;

  assign rs_e = (rsD != 5'd0) && (rsD == wregE) && (tuse_rsD < tnewE);
  assign rs_m = (rsD != 5'd0) && (rsD == wregM) && (tuse_rsD < tnewM);
  assign rt_e = (rtD != 5'd0) && (rtD == wregE) && (tuse_rtD < tnewE);
  assign rt_m = (rtD != 5'd0) && (rtD == wregM) && (tuse_rtD < tnewM);

  assign stall_data = rs_e | rs_m | rt_e | rt_m;
  assign stall_md   = md_useD & (busy | md_startE);
  assign stall      = stall_data | stall_md;
  assign flush      = exc_reqM | eretM;

  // squashed starts never reach the mult/div unit
  md_busy_cnt #(
    .MULT_LAT(MULT_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_md (
    .clk  (clk),
    .rst  (rst),
    .start(md_startE & ~flush),
    .div  (md_divE),
    .busy (busy)
  );

  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    Eclr    = 1'b0;
    DEMWclr = 1'b0;
    pc_sel  = PC_NORM;
    if (rst) begin
      DEMWclr = flush;
      stallF  = stall & ~flush;
      stallD  = stall & ~flush;
      Eclr    = stall & ~flush;
      if (exc_reqM)   pc_sel = PC_EXC;
      else if (eretM) pc_sel = PC_EPC;
    end
  end

  assign md_busy = busy;

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall && !flush && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases then random traffic.
// Expectations come from a cycle-count reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, wregE, wregM;
  logic [1:0] tuse_rsD, tuse_rtD, tnewE, tnewM;
  logic       md_startE, md_divE, md_useD, exc_reqM, eretM;
  logic       stallF, stallD, Eclr, DEMWclr, md_busy;
  logic [1:0] pc_sel;
  logic [31:0] sc_dut;

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt;
  assign sc_dut = stall_cnt;
`else
  assign sc_dut = 32'd0;
`endif

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD),
    .tuse_rsD(tuse_rsD), .tuse_rtD(tuse_rtD),
    .wregE(wregE), .tnewE(tnewE),
    .wregM(wregM), .tnewM(tnewM),
    .md_startE(md_startE), .md_divE(md_divE),
    .md_useD(md_useD), .exc_reqM(exc_reqM), .eretM(eretM),
    .stallF(stallF), .stallD(stallD), .Eclr(Eclr),
    .DEMWclr(DEMWclr), .pc_sel(pc_sel),
`ifdef HAZ_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sf, sd, ec, cl;
    logic [1:0]  pc;
    logic        busy;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   busy_left = 0;
  longint stat_m = 0;

  task automatic step(
    input logic r,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [1:0] urs, input logic [1:0] urt,
    input logic [4:0] we, input logic [1:0] ne,
    input logic [4:0] wm, input logic [1:0] nm,
    input logic st, input logic dv, input logic use_md,
    input logic ex, input logic er);
    exp_t e;
    bit sd_, sm_, stl, fl;
    rst = r; rsD = rs; rtD = rt; tuse_rsD = urs; tuse_rtD = urt;
    wregE = we; tnewE = ne; wregM = wm; tnewM = nm;
    md_startE = st; md_divE = dv; md_useD = use_md;
    exc_reqM = ex; eretM = er;
    if (!r) begin
      busy_left = 0;
      stat_m = 0;
    end
    sd_ = (rs != 0 && rs == we && urs < ne) || (rs != 0 && rs == wm && urs < nm)
       || (rt != 0 && rt == we && urt < ne) || (rt != 0 && rt == wm && urt < nm);
    sm_ = use_md && (busy_left > 0 || st);
    stl = sd_ || sm_;
    fl  = ex || er;
    e = '0;
    if (r) begin
      e.cl = fl;
      e.sf = stl && !fl;
      e.sd = e.sf;
      e.ec = e.sf;
      e.pc = ex ? 2'd1 : (er ? 2'd2 : 2'd0);
      e.busy = busy_left > 0;
    end
`ifdef HAZ_STATS_EN
    e.sc = 32'(stat_m);
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      if (stl && !fl && stat_m < 64'hFFFF_FFFF) stat_m++;
      if (busy_left > 0) busy_left--;
      else if (st && !fl) busy_left = dv ? 10 : 5;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, g;
      e = q.pop_front();
      g = '{sf: stallF, sd: stallD, ec: Eclr, cl: DEMWclr,
            pc: pc_sel, busy: md_busy, sc: sc_dut};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL outputs cyc%0d got sf%b sd%b ec%b cl%b pc%0d busy%b sc%0d exp sf%b sd%b ec%b cl%b pc%0d busy%b sc%0d",
          cyc, g.sf, g.sd, g.ec, g.cl, g.pc, g.busy, g.sc,
          e.sf, e.sd, e.ec, e.cl, e.pc, e.busy, e.sc);
      end
    end
  end

  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(0);
    idle(0);
    idle(1);
    // load-use: lw $1 in E, D reads $1 early
    step(1, 1, 0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    // div then mflo waiting in D
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    // exception over data stall, then exc+eret together
    step(1, 2, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // start squashed by exception, then reset mid-busy
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    idle(1);
    idle(1);
    idle(0);
    idle(1);
    // three counted stalls and one flushed stall
    for (int i = 0; i < 3; i++)
      step(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    for (int i = 0; i < 2000; i++) begin
      logic r, st, ex, er;
      r  = ($urandom_range(0, 99) != 0);
      st = (busy_left == 0) && ($urandom_range(0, 5) == 0);
      ex = ($urandom_range(0, 9) == 0);
      er = ($urandom_range(0, 9) == 0);
      step(r,
        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
        2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
        5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
        5'($urandom_range(0, 3)), 2'($urandom_range(0, 1)),
        st, 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 2) == 0), ex, er);
    end
    idle(1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
